// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - daisy-chained ADC string responder for the ADC SPI master
// Emits periodic DRDY ticks, serialises one frame per tick on MISO and collects MOSI command words.
module adc_spi_responder #(
  parameter int ADC_DCN     = 8,
  parameter int WORD_W      = 8,
  parameter int DRDY_PERIOD = 400,
  parameter int DRDY_LOW    = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              DRDYOUT,
  output logic [WORD_W-1:0] cmd_data,
  output logic              cmd_valid,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        overrun_cnt
);

  localparam int L  = ADC_DCN * WORD_W;
  localparam int CW = $clog2(DRDY_PERIOD);
  localparam int LW = $clog2(DRDY_LOW + 1);
  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, READY, SHIFT} state_t;

  // pipe[0..1] synchronise, pipe[2] is the history flop for edge detection
  logic [2:0]        sclk_pipe_q, sclk_pipe_d;
  logic [2:0]        cs_pipe_q, cs_pipe_d;
  logic [1:0]        mosi_pipe_q, mosi_pipe_d;
  logic [CW-1:0]     per_cnt_q, per_cnt_d;
  logic [LW-1:0]     low_cnt_q, low_cnt_d;
  logic              drdy_q, drdy_d;
  state_t            state_q, state_d;
  logic [L-1:0]      sr_q, sr_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        ovr_q, ovr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] col_q, col_d;
  logic [WORD_W-1:0] cmd_data_q, cmd_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              miso_q, miso_d;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, tick;
  logic              load, ovr_inc;
  logic [L-1:0]      frame_w;
  logic [WORD_W-1:0] col_full;

  assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
  assign cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];
  assign mosi_s    = mosi_pipe_q[1];
  assign tick      = enable & (per_cnt_q == '0);
  assign col_full  = {col_q[WORD_W-2:0], mosi_s};

  // Word 0 occupies the MSBs so it leaves first
  always_comb begin
    frame_w = '0;
    for (int k = 0; k < ADC_DCN; k++) begin
      frame_w[L-1-k*WORD_W -: WORD_W] = WORD_W'(32'(frame_cnt_q) * 32'(ADC_DCN) + 32'(k));
    end
  end

  always_comb begin
    sclk_pipe_d = {sclk_pipe_q[1:0], SCLK};
    cs_pipe_d   = {cs_pipe_q[1:0], CS};
    mosi_pipe_d = {mosi_pipe_q[0], MOSI};

    if (!enable)
      per_cnt_d = '0;
    else if (per_cnt_q == CW'(DRDY_PERIOD - 1))
      per_cnt_d = '0;
    else
      per_cnt_d = per_cnt_q + CW'(1);

    if (tick)
      low_cnt_d = LW'(DRDY_LOW);
    else if (low_cnt_q != '0)
      low_cnt_d = low_cnt_q - LW'(1);
    else
      low_cnt_d = '0;
    drdy_d = (low_cnt_d == '0);

    state_d     = state_q;
    sr_d        = sr_q;
    frame_cnt_d = frame_cnt_q;
    ovr_d       = ovr_q;
    bit_cnt_d   = bit_cnt_q;
    col_d       = col_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    load        = 1'b0;
    ovr_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          load    = 1'b1;
          state_d = READY;
        end
        if (cs_fall) state_d = SHIFT;
      end
      READY: begin
        if (tick) begin
          load    = 1'b1;
          ovr_inc = 1'b1;
        end
        if (cs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) ovr_inc = 1'b1;
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          if (sclk_rise) sr_d = {sr_q[L-2:0], 1'b0};
          if (sclk_fall) begin
            col_d = col_full;
            if (bit_cnt_q == BW'(WORD_W - 1)) begin
              cmd_data_d  = col_full;
              cmd_valid_d = 1'b1;
              bit_cnt_d   = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d        = frame_w;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (ovr_inc && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    if (cs_fall) bit_cnt_d = '0;

    miso_d = (state_d == SHIFT) & sr_d[L-1];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_pipe_q <= 3'b000;
      cs_pipe_q   <= 3'b111;
      mosi_pipe_q <= 2'b00;
      per_cnt_q   <= '0;
      low_cnt_q   <= '0;
      drdy_q      <= 1'b1;
      state_q     <= IDLE;
      sr_q        <= '0;
      frame_cnt_q <= '0;
      ovr_q       <= '0;
      bit_cnt_q   <= '0;
      col_q       <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      cs_pipe_q   <= cs_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      per_cnt_q   <= per_cnt_d;
      low_cnt_q   <= low_cnt_d;
      drdy_q      <= drdy_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_q       <= ovr_d;
      bit_cnt_q   <= bit_cnt_d;
      col_q       <= col_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      miso_q      <= miso_d;
    end
  end

  assign MISO        = miso_q;
  assign DRDYOUT     = drdy_q;
  assign cmd_data    = cmd_data_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
Synthesizable responder model of one daisy-chained ADC string. It is the far end of the DRDYOUT/CS/SCLK/MOSI/MISO link driven by the system's ADC SPI master, and one instance is placed per daisy-chain lane. It generates periodic data-ready pulses and serialises a deterministic frame of ADC_DCN words onto MISO. It also captures MOSI command words and reports overrun statistics. It runs entirely in the sys_clk domain and oversamples the master's SCLK/CS/MOSI.

Parameters:
ADC_DCN, 8, number of devices (words) per daisy-chain frame
WORD_W, 8, bits per device word
DRDY_PERIOD, 400, sys_clk cycles between data-ready ticks (>= 2)
DRDY_LOW, 3, sys_clk cycles DRDYOUT is held low per tick (1..DRDY_PERIOD-1)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous active-high reset
enable  in  1  1 = generate DRDY ticks; 0 = period counter held at 0, no ticks
SCLK  in  1  SPI clock from master (CPOL=0), asynchronous to sys_clk
CS  in  1  active-low chip select from master
MOSI  in  1  master-to-responder serial data
MISO  out  1  responder-to-master serial data, MSB first
DRDYOUT  out  1  active-low data-ready pulse
cmd_data  out  WORD_W  last complete MOSI word
cmd_valid  out  1  one-cycle strobe when cmd_data updates
frame_cnt  out  16  frames loaded since reset, wraps at 2^16
overrun_cnt  out  8  ticks that arrived with a frame unread or in transfer; saturates at 255

Behaviour:
- Reset values: MISO=0, DRDYOUT=1, cmd_data=0, cmd_valid=0, frame_cnt=0, overrun_cnt=0, state=IDLE, period counter=0, shift register=0.
- Input sync: SCLK, CS and MOSI each pass through a 2-flop synchroniser plus one history flop. Edges are detected on synchronised values, giving a 3-cycle detect latency. The master must hold each SCLK phase for at least 4 sys_clk cycles.
- Tick: the period counter runs 0..DRDY_PERIOD-1 while enable=1. A tick occurs when the counter equals 0 with enable=1. DRDYOUT is 0 for DRDY_LOW cycles, starting in the cycle after the tick.
- Frame content: word k (k=0..ADC_DCN-1) = (frame_cnt*ADC_DCN + k) mod 2^WORD_W, evaluated with the pre-increment frame_cnt. Word 0 is transmitted first, MSB first. Total length is L = ADC_DCN*WORD_W bits.
- Load: the tick writes the frame into the L-bit shift register and increments frame_cnt.
- State machine:
  - IDLE: a tick loads the frame and moves to READY.
  - READY: a tick increments overrun_cnt and reloads the frame (newest data wins, frame_cnt increments). A detected CS fall moves to SHIFT.
  - IDLE + CS fall: moves to SHIFT and shifts out the currently held register contents (stale data).
  - SHIFT: a tick increments overrun_cnt, does not reload and does not increment frame_cnt. A detected CS rise moves to IDLE, whether or not all L bits were read; a partially read frame is discarded.
- MISO: equals shift register MSB while in SHIFT, 0 otherwise. On each detected SCLK rise in SHIFT the register shifts left, filling with 0. After L rises MISO stays 0. The master samples on SCLK fall.
- MOSI capture: on each detected SCLK fall in SHIFT, the synchronised MOSI is shifted into a WORD_W collector and a bit counter increments.
  - When WORD_W bits have been collected, cmd_data updates and cmd_valid=1 for exactly one cycle.
  - The bit counter clears on CS fall. A partial word is dropped at CS rise.
- Simultaneous events:
  - Tick and CS fall in the same cycle in IDLE/READY: the load takes priority and SHIFT starts with the new frame. In READY this also counts as an overrun.
  - Tick and CS rise in the same cycle in SHIFT: counts as an overrun and the state becomes IDLE with no load.
- enable deassert mid-pulse: DRDYOUT completes its DRDY_LOW pulse.
- sys_rst mid-transfer: all state returns to reset values immediately. MISO=0 and DRDYOUT=1 asynchronously.
- overrun_cnt holds at 255. frame_cnt wraps 65535 -> 0.

Test Plan:
- Reset, enable=1, default params -> first DRDYOUT low at cycles 1..3 after the first tick, then every 400 cycles; frame_cnt=1 after the first tick.
- After the first tick, master reads 64 bits (SCLK half period 5 cycles) -> MISO bytes 0x00,0x01,...,0x07. After the second tick and read: 0x08..0x0F.
- Skip reading for 3 ticks, then read -> overrun_cnt=2, frame_cnt=3, data 0x10..0x17.
- Hold CS low across a tick -> overrun_cnt increments by 1, frame_cnt unchanged, shifted data remains the old frame.
- Master sends MOSI 0xA5 then 0x3C in one transfer -> two single-cycle cmd_valid pulses with cmd_data 0xA5 then 0x3C. Raising CS after 4 further bits -> no third pulse.
- Assert sys_rst after 20 bits of a transfer -> MISO=0, DRDYOUT=1, counters 0. After release, next read returns 0x00..0x07.
